// File: rtl/node_step_sched.sv
// node_step_sched: time-step scheduler for one neuron node.
//
// It drives the work controller through its tik / config_enable /
// config_clear inputs. A run starts with run_start. The run can first clear
// the membranes. It then issues N time steps. Each step is a TIK_W-cycle tik
// pulse, followed by a GUARD-cycle blind window, followed by a wait for the
// work controller to drop work_busy. An optional idle gap separates steps.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   run_start        single-cycle start request (IDLE only)
//   run_abort        synchronous abort, any state
//   cfg_step_num     steps per run     (sampled with run_start)
//   cfg_gap          inter-step gap    (sampled with run_start)
//   cfg_clear_first  clear before step (sampled with run_start)
//   work_busy        work controller busy
//   clear_done       work controller clear-complete pulse
//   tik              time-step tick to the work controller
//   config_enable    enable to the work controller
//   config_clear     clear request to the work controller
//   run_busy         scheduler not idle
//   step_cnt         completed steps of the current / last run
//   run_done         one-cycle run completion pulse
module node_step_sched #(
  parameter int STEP_W = 16,
  parameter int GAP_W  = 8,
  parameter int TIK_W  = 2,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_start,
  input  logic              run_abort,
  input  logic [STEP_W-1:0] cfg_step_num,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              cfg_clear_first,
  input  logic              work_busy,
  input  logic              clear_done,
  output logic              tik,
  output logic              config_enable,
  output logic              config_clear,
  output logic              run_busy,
  output logic [STEP_W-1:0] step_cnt,
  output logic              run_done
);

  // The phase counter is shared by TIK_HI, GUARD_W and GAP, so it must be
  // wide enough for the longest of the three.
  localparam int PH_MAX = (TIK_W > GUARD) ? TIK_W : GUARD;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = (GAP_W > PH_W) ? GAP_W : PH_W;

  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TIK_LAST   = CNT_W'(TIK_W - 1);
  localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [STEP_W-1:0] STEP_ZERO  = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ZERO   = {GAP_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_TIK_HI    = 3'd2,
    ST_GUARD_W   = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [STEP_W-1:0] step_num_r, step_num_s;
  logic [GAP_W-1:0]  gap_r, gap_s;
  logic [STEP_W-1:0] step_cnt_s;
  logic [STEP_W-1:0] step_inc_s;
  logic              zero_done_s;

  // Next-state, counter and latched-config logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    step_num_s  = step_num_r;
    gap_s       = gap_r;
    step_cnt_s  = step_cnt;
    zero_done_s = 1'b0;
    step_inc_s  = step_cnt + STEP_ONE;

    if (run_abort) begin
      // Abort beats everything, including a start seen in IDLE.
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run_start) begin
            step_cnt_s = STEP_ZERO;
            if (cfg_step_num != STEP_ZERO) begin
              step_num_s = cfg_step_num;
              gap_s      = cfg_gap;
              cnt_s      = CNT_ZERO;
              if (cfg_clear_first) begin
                state_s = ST_CLEAR;
              end else begin
                state_s = ST_TIK_HI;
              end
            end else begin
              // Empty run: complete at once without leaving IDLE.
              zero_done_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (clear_done) begin
            state_s = ST_TIK_HI;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = ST_CLEAR;
          end
        end
        ST_TIK_HI: begin
          if (cnt_r == TIK_LAST) begin
            state_s = ST_GUARD_W;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_GUARD_W: begin
          // work_busy may still show the previous step here because the work
          // controller needs a few cycles to see the tik edge.
          if (cnt_r == GUARD_LAST) begin
            state_s = ST_WAIT_BUSY;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_BUSY: begin
          if (!work_busy) begin
            step_cnt_s = step_inc_s;
            cnt_s      = CNT_ZERO;
            if (step_inc_s == step_num_r) begin
              state_s = ST_DONE;
            end else if (gap_r != GAP_ZERO) begin
              state_s = ST_GAP;
            end else begin
              state_s = ST_TIK_HI;
            end
          end else begin
            state_s = ST_WAIT_BUSY;
          end
        end
        ST_GAP: begin
          if ((cnt_r + CNT_ONE) == CNT_W'(gap_r)) begin
            state_s = ST_TIK_HI;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered outputs. Outputs are decoded from the
  // next state so that each one lines up exactly with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      step_num_r    <= STEP_ZERO;
      gap_r         <= GAP_ZERO;
      step_cnt      <= STEP_ZERO;
      tik           <= 1'b0;
      config_enable <= 1'b0;
      config_clear  <= 1'b0;
      run_busy      <= 1'b0;
      run_done      <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      step_num_r    <= step_num_s;
      gap_r         <= gap_s;
      step_cnt      <= step_cnt_s;
      tik           <= (state_s == ST_TIK_HI);
      config_clear  <= (state_s == ST_CLEAR);
      config_enable <= (state_s inside {ST_TIK_HI, ST_GUARD_W, ST_WAIT_BUSY,
                                        ST_GAP, ST_DONE});
      run_busy      <= (state_s != ST_IDLE);
      run_done      <= (state_s == ST_DONE) | zero_done_s;
    end
  end

endmodule

// File: tb/tb_node_step_sched.sv
// Self-checking bench for node_step_sched. A run is described by the
// timeline it should produce. That timeline is built from event arithmetic:
// tik windows, busy windows, step completion cycles and a done cycle. The
// bench compares every cycle of the DUT outputs against it.
module tb_node_step_sched;

  localparam int STEP_W = 16;
  localparam int GAP_W  = 8;
  localparam int TIK_W  = 2;
  localparam int GUARD  = 4;
  localparam int VW     = STEP_W + 5;
  localparam int MAXC   = 512;

  logic              clk;
  logic              rst_n;
  logic              run_start;
  logic              run_abort;
  logic [STEP_W-1:0] cfg_step_num;
  logic [GAP_W-1:0]  cfg_gap;
  logic              cfg_clear_first;
  logic              work_busy;
  logic              clear_done;
  logic              tik;
  logic              config_enable;
  logic              config_clear;
  logic              run_busy;
  logic [STEP_W-1:0] step_cnt;
  logic              run_done;

  node_step_sched #(.STEP_W(STEP_W), .GAP_W(GAP_W), .TIK_W(TIK_W), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .run_start(run_start), .run_abort(run_abort),
    .cfg_step_num(cfg_step_num), .cfg_gap(cfg_gap), .cfg_clear_first(cfg_clear_first),
    .work_busy(work_busy), .clear_done(clear_done), .tik(tik),
    .config_enable(config_enable), .config_clear(config_clear),
    .run_busy(run_busy), .step_cnt(step_cnt), .run_done(run_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Stimulus per cycle.
  bit              start_v [MAXC];
  bit              abort_v [MAXC];
  bit              busy_v  [MAXC];
  bit              cdone_v [MAXC];
  bit              clrf_v  [MAXC];
  logic [STEP_W-1:0] num_v [MAXC];
  logic [GAP_W-1:0]  gap_v [MAXC];
  // Expected outputs per cycle.
  bit              e_tik [MAXC];
  bit              e_en  [MAXC];
  bit              e_clr [MAXC];
  bit              e_rb  [MAXC];
  bit              e_done[MAXC];
  logic [STEP_W-1:0] e_cnt [MAXC];
  // Observed outputs per cycle.
  logic [VW-1:0]   obs_v [MAXC];

  int wcyc [64];
  int done_c;
  int last_c;
  int tik_first;
  logic [STEP_W-1:0] prev_cnt;

  function automatic logic [VW-1:0] exp_at(input int i);
    return {e_tik[i], e_en[i], e_clr[i], e_rb[i], e_done[i], e_cnt[i]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      start_v[i] = 1'b0; abort_v[i] = 1'b0; busy_v[i] = 1'b0; cdone_v[i] = 1'b0;
      clrf_v[i] = 1'b0; num_v[i] = '0; gap_v[i] = '0;
      e_tik[i] = 1'b0; e_en[i] = 1'b0; e_clr[i] = 1'b0; e_rb[i] = 1'b0;
      e_done[i] = 1'b0; e_cnt[i] = prev_cnt;
    end
  endtask

  // Build the timeline of a run that is started in cycle 0. The clear
  // completes in cycle cd. For each step, busy rises d cycles after tik
  // falls and stays high for l cycles. d <= GUARD keeps every busy window
  // inside its own step.
  task automatic build(input int n, input int gap, input int clr, input int cd,
                       input int d, input int l);
    int t, w, x, ws, we;
    clear_model();
    start_v[0] = 1'b1;
    num_v[0]   = STEP_W'(n);
    gap_v[0]   = GAP_W'(gap);
    clrf_v[0]  = (clr != 0);
    if (n == 0) begin
      for (int i = 1; i < MAXC; i++) e_cnt[i] = '0;
      e_done[1] = 1'b1;
      done_c = 1;
    end else begin
      for (int i = 1; i < MAXC; i++) e_cnt[i] = '0;
      t = 1;
      if (clr != 0) begin
        for (int i = 1; i <= cd; i++) begin
          e_clr[i] = 1'b1;
        end
        cdone_v[cd] = 1'b1;
        t = cd + 1;
      end
      tik_first = t;
      for (int k = 1; k <= n; k++) begin
        for (int i = t; i < t + TIK_W; i++) e_tik[i] = 1'b1;
        ws = t + TIK_W + d;
        we = ws + l - 1;
        for (int i = ws; i <= we; i++) busy_v[i] = 1'b1;
        w = t + TIK_W + GUARD;
        wcyc[k] = w;
        x = w;
        if (l > 0 && x >= ws && x <= we) x = we + 1;
        for (int i = x + 1; i < MAXC; i++) e_cnt[i] = STEP_W'(k);
        if (k == n) done_c = x + 1;
        else t = x + 1 + gap;
      end
      for (int i = tik_first; i <= done_c; i++) e_en[i] = 1'b1;
      for (int i = 1; i <= done_c; i++) e_rb[i] = 1'b1;
      e_done[done_c] = 1'b1;
    end
    last_c = done_c + 3;
  endtask

  // An abort seen in cycle a freezes step_cnt and idles everything else.
  task automatic apply_abort(input int a);
    abort_v[a] = 1'b1;
    for (int i = a + 1; i < MAXC; i++) begin
      e_tik[i] = 1'b0; e_en[i] = 1'b0; e_clr[i] = 1'b0; e_rb[i] = 1'b0;
      e_done[i] = 1'b0; e_cnt[i] = e_cnt[a];
    end
    last_c = a + 3;
  endtask

  // Drive cycles 0..last_c and record the outputs at each falling edge.
  task automatic run_cycles();
    for (int i = 0; i <= last_c; i++) begin
      @(posedge clk);
      #1;
      run_start       = start_v[i];
      run_abort       = abort_v[i];
      cfg_step_num    = num_v[i];
      cfg_gap         = gap_v[i];
      cfg_clear_first = clrf_v[i];
      work_busy       = busy_v[i];
      clear_done      = cdone_v[i];
      @(negedge clk);
      obs_v[i] = {tik, config_enable, config_clear, run_busy, run_done, step_cnt};
    end
    prev_cnt = e_cnt[last_c];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run_start = 1'b0; run_abort = 1'b0; cfg_step_num = '0; cfg_gap = '0;
    cfg_clear_first = 1'b0; work_busy = 1'b0; clear_done = 1'b0;
    prev_cnt = '0;
    #3;
    vec_cnt++;
    if ({tik, config_enable, config_clear, run_busy, run_done, step_cnt} !== {VW{1'b0}}) begin
      err_cnt++;
      $display("FAIL reset_values: got %h want 0",
               {tik, config_enable, config_clear, run_busy, run_done, step_cnt});
    end
    #9 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int rises;
    build(3, 0, 0, 1, 4, 10);
    run_cycles();
    rises = 0;
    for (int i = 0; i <= last_c; i++) begin
      vec_cnt++;
      if (obs_v[i] !== exp_at(i)) begin
        err_cnt++;
        $display("FAIL basic cyc %0d: got %h want %h", i, obs_v[i], exp_at(i));
      end
      if (i > 0 && obs_v[i][VW-1] === 1'b1 && obs_v[i-1][VW-1] === 1'b0) rises++;
    end
    vec_cnt++;
    if (rises !== 3) begin
      err_cnt++;
      $display("FAIL basic_tik_count: got %0d want 3", rises);
    end
  endtask

  task automatic test_clear_first();
    build(1, 0, 1, 20, $urandom_range(GUARD), $urandom_range(10));
    run_cycles();
    for (int i = 0; i <= last_c; i++) begin
      vec_cnt++;
      if (obs_v[i] !== exp_at(i)) begin
        err_cnt++;
        $display("FAIL clear_first cyc %0d: got %h want %h", i, obs_v[i], exp_at(i));
      end
    end
  endtask

  task automatic test_gap();
    int r0, r1;
    build(2, 5, 0, 1, 0, 0);
    run_cycles();
    r0 = -1; r1 = -1;
    for (int i = 0; i <= last_c; i++) begin
      vec_cnt++;
      if (obs_v[i] !== exp_at(i)) begin
        err_cnt++;
        $display("FAIL gap cyc %0d: got %h want %h", i, obs_v[i], exp_at(i));
      end
      if (i > 0 && obs_v[i][VW-1] === 1'b1 && obs_v[i-1][VW-1] === 1'b0) begin
        if (r0 < 0) r0 = i;
        else if (r1 < 0) r1 = i;
      end
    end
    vec_cnt++;
    if (r1 - r0 !== 12) begin
      err_cnt++;
      $display("FAIL gap_tik_period: got %0d want 12", r1 - r0);
    end
  endtask

  task automatic test_zero_steps();
    build(0, 3, 1, 1, 0, 0);
    run_cycles();
    for (int i = 0; i <= last_c; i++) begin
      vec_cnt++;
      if (obs_v[i] !== exp_at(i)) begin
        err_cnt++;
        $display("FAIL zero_steps cyc %0d: got %h want %h", i, obs_v[i], exp_at(i));
      end
    end
  endtask

  task automatic test_abort();
    build(10, 0, 0, 1, 4, 10);
    apply_abort(wcyc[4] + 3);
    run_cycles();
    for (int i = 0; i <= last_c; i++) begin
      vec_cnt++;
      if (obs_v[i] !== exp_at(i)) begin
        err_cnt++;
        $display("FAIL abort cyc %0d: got %h want %h", i, obs_v[i], exp_at(i));
      end
    end
    vec_cnt++;
    if (obs_v[last_c][STEP_W-1:0] !== 16'd3) begin
      err_cnt++;
      $display("FAIL abort_step_cnt: got %0d want 3", obs_v[last_c][STEP_W-1:0]);
    end
    // Abort together with start in IDLE: the start must be ignored.
    build(3, 0, 0, 1, 0, 0);
    apply_abort(0);
    run_cycles();
    for (int i = 0; i <= last_c; i++) begin
      vec_cnt++;
      if (obs_v[i] !== exp_at(i)) begin
        err_cnt++;
        $display("FAIL abort_start cyc %0d: got %h want %h", i, obs_v[i], exp_at(i));
      end
    end
  endtask

  task automatic test_ignored_start();
    build(2, 0, 0, 1, 2, 6);
    // A restart in mid-run and a restart in DONE must both be ignored. A
    // stray clear_done outside CLEAR must have no effect.
    start_v[5] = 1'b1; num_v[5] = 16'd7; gap_v[5] = 8'd3; clrf_v[5] = 1'b1;
    cdone_v[6] = 1'b1;
    start_v[done_c] = 1'b1; num_v[done_c] = 16'd7;
    run_cycles();
    for (int i = 0; i <= last_c; i++) begin
      vec_cnt++;
      if (obs_v[i] !== exp_at(i)) begin
        err_cnt++;
        $display("FAIL ignored_start cyc %0d: got %h want %h", i, obs_v[i], exp_at(i));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk);
    #1;
    run_start = 1'b1; cfg_step_num = 16'd4; cfg_gap = 8'd0; cfg_clear_first = 1'b0;
    @(posedge clk);
    #1;
    run_start = 1'b0;
    #2;
    vec_cnt++;
    if (tik !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_mid_tik_high: got %b want 1", tik);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({tik, config_enable, config_clear, run_busy, run_done, step_cnt} !== {VW{1'b0}}) begin
      err_cnt++;
      $display("FAIL reset_mid_outputs: got %h want 0",
               {tik, config_enable, config_clear, run_busy, run_done, step_cnt});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_cnt = '0;
    repeat (3) begin
      @(negedge clk);
      vec_cnt++;
      if ({tik, config_enable, config_clear, run_busy, run_done, step_cnt} !== {VW{1'b0}}) begin
        err_cnt++;
        $display("FAIL reset_mid_quiet: got %h want 0",
                 {tik, config_enable, config_clear, run_busy, run_done, step_cnt});
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(5);
      build(n, $urandom_range(6), $urandom_range(1), $urandom_range(8, 1),
            $urandom_range(GUARD), $urandom_range(10));
      if (n != 0) cdone_v[done_c] = 1'b1;
      busy_v[done_c + 1] = 1'b1;
      if ($urandom_range(2) == 0) apply_abort($urandom_range(done_c));
      run_cycles();
      for (int i = 0; i <= last_c; i++) begin
        vec_cnt++;
        if (obs_v[i] !== exp_at(i)) begin
          err_cnt++;
          $display("FAIL random run %0d cyc %0d: got %h want %h", r, i, obs_v[i], exp_at(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear_first();
    test_gap();
    test_zero_steps();
    test_abort();
    test_ignored_start();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/node_step_sched.md
Name: node_step_sched

Overview:
- Time-step scheduler for one neuron node. It sequences the node's work controller by driving its `tik`, `config_enable` and `config_clear` inputs.
- A host-side start launches a run of N time steps, with an optional membrane clear beforehand.
- Each step raises one `tik` pulse, then waits until the work controller has accepted and finished the step (busy low) before the next step.
- Reports step progress and a one-cycle done pulse.

Parameters:
- STEP_W, 16, width of the step-count request and progress counter
- GAP_W, 8, width of the inter-step idle-gap count
- TIK_W, 2, `tik` high width in cycles (≥1)
- GUARD, 4, cycles after `tik` falls before `work_busy` is sampled; covers the work controller's 3-cycle tik edge-detect delay (≥4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run_start  in  1  single-cycle start request; honoured only in IDLE
- run_abort  in  1  synchronous abort, any state
- cfg_step_num  in  STEP_W  number of steps; sampled with `run_start`
- cfg_gap  in  GAP_W  idle cycles between steps; sampled with `run_start`
- cfg_clear_first  in  1  clear membranes before step 1; sampled with `run_start`
- work_busy  in  1  work controller busy (its state not idle)
- clear_done  in  1  work controller clear-complete pulse
- tik  out  1  time-step tick to the work controller
- config_enable  out  1  enable to the work controller
- config_clear  out  1  clear request to the work controller
- run_busy  out  1  high in any state except IDLE
- step_cnt  out  STEP_W  completed steps in the current or last run
- run_done  out  1  one-cycle pulse at run completion

Behaviour:
- All outputs are registered. Reset values are 0 for every output; FSM resets to IDLE; internal counters reset to 0.
- States: IDLE, CLEAR, TIK_HI, GUARD_W, WAIT_BUSY, GAP, DONE.
- Output decode by state:
  - `config_enable` = 1 in TIK_HI, GUARD_W, WAIT_BUSY, GAP, DONE; 0 in IDLE and CLEAR.
  - `config_clear` = 1 only in CLEAR.
  - `tik` = 1 only in TIK_HI.
- IDLE:
  - `run_start` with `cfg_step_num` ≠ 0: latch the three cfg inputs and clear `step_cnt`. Next state is CLEAR if `cfg_clear_first`, else TIK_HI.
  - `run_start` with `cfg_step_num` = 0: `step_cnt` cleared, `run_done` pulses the next cycle, FSM stays in IDLE.
- CLEAR:
  - Hold `config_clear` = 1 until `clear_done` = 1 is sampled, then go to TIK_HI.
  - No timeout; only `run_abort` or reset exits.
- TIK_HI: lasts exactly TIK_W cycles, then GUARD_W.
- GUARD_W: lasts exactly GUARD cycles; `work_busy` is ignored here. Then WAIT_BUSY.
- WAIT_BUSY:
  - Stay while `work_busy` = 1.
  - On the first cycle with `work_busy` = 0, increment `step_cnt`.
  - If the new count equals the latched step number, go to DONE.
  - Otherwise go to GAP if latched gap ≠ 0, else directly to TIK_HI.
- GAP: lasts exactly the latched gap count of cycles, then TIK_HI.
- DONE: `run_done` = 1 for one cycle, then IDLE. `step_cnt` holds its final value until the next `run_start`.
- `run_abort`:
  - Highest priority after reset; from any non-IDLE state, next state is IDLE.
  - `tik`, `config_clear` and `config_enable` drop the following cycle.
  - No `run_done`; `step_cnt` keeps the completed count.
  - `run_abort` and `run_start` together in IDLE: the abort wins and the start is ignored.
- `run_start` while `run_busy` = 1 is ignored; cfg inputs are not re-sampled.
- `step_cnt` never wraps, because termination compares against the latched N, which is at most 2^STEP_W−1.
- Asynchronous reset mid-run: all outputs go to 0 immediately; no `run_done`.
- `clear_done` outside CLEAR and `work_busy` outside WAIT_BUSY have no effect.

Test Plan:
1. Basic run, N=3, gap=0, clear=0, `work_busy` model rising 4 cycles after `tik` falls and lasting 10 cycles.
   - Expect 3 `tik` pulses, each 2 cycles wide.
   - Expect `step_cnt` to read 1, 2, 3.
   - Expect one `run_done` pulse, then `run_busy` = 0.
2. Clear first, N=1, clear=1, `clear_done` pulsed 20 cycles after start.
   - Expect `config_clear` = 1 with `config_enable` = 0 for those 20 cycles.
   - Then `tik` the cycle after `clear_done`, then `run_done`.
3. Gap timing, N=2, gap=5, `work_busy` tied to 0.
   - Expect exactly 5 cycles between the falling edge of WAIT_BUSY and the second `tik`.
   - Expect the `tik` period to equal TIK_W+GUARD+1+5 = 12 cycles.
4. Zero steps, N=0.
   - Expect no `tik`, `run_done` on the next cycle, `step_cnt` = 0.
5. Abort, N=10, `run_abort` during the 4th WAIT_BUSY.
   - Expect `tik`, `config_enable` = 0 and `run_busy` = 0 the next cycle.
   - Expect `step_cnt` = 3 and no `run_done`.
6. Ignored start and reset.
   - `run_start` with N=7 mid-run (N=2): the run still ends at `step_cnt` = 2.
   - Reset asserted in TIK_HI: `tik` drops immediately, all outputs 0.
